// File: rtl/sync_fifo_fwft_pro.sv
// rtl/sync_fifo_fwft_pro.sv - first-word-fall-through synchronous FIFO
// Circular buffer plus a registered head copy on dout; all flags registered from post-edge occupancy.
module sync_fifo_fwft_pro #(
  parameter int DW        = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DW-1:0]              din,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DW-1:0]              dout,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     usedw,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;
  localparam logic [UW-1:0] DEPTH_U  = UW'(DEPTH);
  localparam logic [UW-1:0] AFULL_U  = UW'(AFULL_TH);
  localparam logic [UW-1:0] AEMPTY_U = UW'(AEMPTY_TH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [UW-1:0] usedw_nxt;
  logic          rd_ok, wr_ok, bypass;

  assign rd_ok      = rd_en && !empty;
  assign wr_ok      = wr_en && (!full || rd_ok);
  assign usedw_nxt  = usedw + UW'(wr_ok) - UW'(rd_ok);
  assign rd_ptr_nxt = rd_ptr + AW'(rd_ok);
  // The incoming word becomes the head when nothing else is left after this edge's pop.
  assign bypass     = wr_ok && (usedw == UW'(rd_ok));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      dout         <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= (AFULL_U == '0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr       <= rd_ptr_nxt;
      usedw        <= usedw_nxt;
      if (bypass)
        dout <= din;
      else if (usedw_nxt != '0)
        dout <= mem[rd_ptr_nxt];
      empty        <= (usedw_nxt == '0);
      full         <= (usedw_nxt == DEPTH_U);
      almost_full  <= (usedw_nxt >= AFULL_U);
      almost_empty <= (usedw_nxt <= AEMPTY_U);
      overflow     <= wr_en && !wr_ok;
      underflow    <= rd_en && !rd_ok;
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft_pro.sv
// tb/tb_sync_fifo_fwft_pro.sv - directed bench for sync_fifo_fwft_pro
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_sync_fifo_fwft_pro;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] din;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
  logic [DW-1:0] dout;
  logic [3:0]    usedw;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q[$];
  logic [7:0] exp_tail [8];

  sync_fifo_fwft_pro #(.DW(DW), .DEPTH(DEPTH), .AFULL_TH(DEPTH-2), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .dout(dout), .empty(empty),
    .almost_empty(almost_empty), .usedw(usedw), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    tick(); tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_usedw", 32'(usedw), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_dout", 32'(dout), 0);
    rst_n = 1'b1;
    tick();

    // single word in and out
    wr_en = 1'b1; din = 8'h11; tick(); wr_en = 1'b0;
    chk("t1_empty", 32'(empty), 0);
    chk("t1_dout", 32'(dout), 32'h11);
    chk("t1_usedw", 32'(usedw), 1);
    chk("t1_ae", 32'(almost_empty), 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t1_pop_empty", 32'(empty), 1);
    chk("t1_pop_usedw", 32'(usedw), 0);

    // fill then drain back-to-back
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; din = 8'(i); tick();
      chk("t2_usedw", 32'(usedw), 32'(i));
      chk("t2_af", 32'(almost_full), (i >= 6) ? 1 : 0);
      chk("t2_ae", 32'(almost_empty), (i <= 2) ? 1 : 0);
      chk("t2_full", 32'(full), (i == 8) ? 1 : 0);
    end
    wr_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_rd_dout", 32'(dout), 32'(i));
      chk("t2_rd_empty", 32'(empty), 0);
      rd_en = 1'b1; tick();
    end
    rd_en = 1'b0;
    chk("t2_end_empty", 32'(empty), 1);
    chk("t2_end_usedw", 32'(usedw), 0);

    // refill, then simultaneous read/write at full
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; din = 8'(i); tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_pop_dout", 32'(dout), 32'(k + 1));
      wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'hA0 + k); tick();
      chk("t3_full", 32'(full), 1);
      chk("t3_usedw", 32'(usedw), 8);
      chk("t3_ovf", 32'(overflow), 0);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // write rejected at full
    wr_en = 1'b1; din = 8'hFF; tick(); wr_en = 1'b0;
    chk("t4_ovf_pulse", 32'(overflow), 1);
    chk("t4_ovf_usedw", 32'(usedw), 8);
    tick();
    chk("t4_ovf_clear", 32'(overflow), 0);
    exp_tail = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hA0, 8'hA1, 8'hA2};
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain_dout", 32'(dout), 32'(exp_tail[i]));
      rd_en = 1'b1; tick();
    end
    rd_en = 1'b0;
    chk("t4_drain_empty", 32'(empty), 1);

    // read rejected when empty
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t4_unf_pulse", 32'(underflow), 1);
    chk("t4_unf_dout", 32'(dout), 32'hA2);
    chk("t4_unf_empty", 32'(empty), 1);
    chk("t4_unf_usedw", 32'(usedw), 0);
    tick();
    chk("t4_unf_clear", 32'(underflow), 0);

    // read+write at usedw==1 replaces the head
    wr_en = 1'b1; din = 8'h55; tick(); wr_en = 1'b0;
    chk("t5_dout55", 32'(dout), 32'h55);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h66; tick(); wr_en = 1'b0; rd_en = 1'b0;
    chk("t5_dout66", 32'(dout), 32'h66);
    chk("t5_empty", 32'(empty), 0);
    chk("t5_usedw", 32'(usedw), 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t5_empty_after", 32'(empty), 1);

    // 20 writes with streaming reads wrap the pointers more than twice
    q.delete();
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; din = 8'(8'h80 + 3 * i);
      rd_en = (i > 0);
      if (rd_en) begin
        chk("t6_stream_dout", 32'(dout), 32'(q[0]));
        void'(q.pop_front());
      end
      q.push_back(din);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t6_usedw", 32'(usedw), 1);
    chk("t6_dout", 32'(dout), 32'(q[0]));

    // asynchronous reset mid-cycle, no clock edge before the check
    wr_en = 1'b1; din = 8'h77; tick(); wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_empty", 32'(empty), 1);
    chk("t6_arst_usedw", 32'(usedw), 0);
    chk("t6_arst_full", 32'(full), 0);
    chk("t6_arst_dout", 32'(dout), 0);
    tick();
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; din = 8'h3C; tick(); wr_en = 1'b0;
    chk("t6_post_dout", 32'(dout), 32'h3C);
    chk("t6_post_usedw", 32'(usedw), 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t6_post_empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
